// File: rtl/divider_job_sched.sv
// Job scheduler for a line-by-line divider core: queues {base, lines} jobs,
// issues one scratchpad read per line and waits for the core's completion pulse.
module divider_job_sched #(
  parameter int unsigned STRIDE  = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_base,
  input  logic [6:0]  job_lines,
  input  logic        div_done,
  output logic [15:0] sc_mem_rdaddr,
  output logic        sc_mem_rd_en,
  output logic        job_done,
  output logic        job_err,
  output logic        busy,
  output logic [6:0]  lines_done
);
  localparam int unsigned AW    = 16;
  localparam int unsigned LW    = 7;
  localparam int unsigned CW    = 2;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam int unsigned MAXL  = 64;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_COMPLETE = 3'd4;
  localparam logic [2:0] S_ERROR    = 3'd5;

  logic [2:0]    state, state_n;
  logic [AW-1:0] q_base [2];
  logic [LW-1:0] q_lines [2];
  logic          q_rd, q_wr;
  logic [CW-1:0] q_cnt, q_cnt_n;
  logic          push, pop;
  logic [AW-1:0] head_base;
  logic [LW-1:0] head_lines;
  logic [LW-1:0] cur_lines, cur_lines_n;
  logic [LW-1:0] lines_done_n;
  logic [AW-1:0] rdaddr_n;
  logic [TW-1:0] tcnt, tcnt_n;

  assign push       = job_valid && job_ready;
  assign pop        = (state == S_LOAD);
  assign head_base  = q_base[q_rd];
  assign head_lines = q_lines[q_rd];

  // Queue occupancy: simultaneous push and pop leaves it unchanged
  always_comb begin
    q_cnt_n = q_cnt;
    case ({push, pop})
      2'b10:   q_cnt_n = q_cnt + CW'(1);
      2'b01:   q_cnt_n = q_cnt - CW'(1);
      default: q_cnt_n = q_cnt;
    endcase
  end

  // Payload storage carries no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) begin
      q_base[q_wr]  <= job_base;
      q_lines[q_wr] <= job_lines;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_rd  <= 1'b0;
      q_wr  <= 1'b0;
      q_cnt <= '0;
    end else begin
      if (push) q_wr <= ~q_wr;
      if (pop)  q_rd <= ~q_rd;
      q_cnt <= q_cnt_n;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_n      = state;
    cur_lines_n  = cur_lines;
    lines_done_n = lines_done;
    rdaddr_n     = sc_mem_rdaddr;
    tcnt_n       = tcnt;
    case (state)
      S_IDLE: begin
        if (q_cnt != '0) state_n = S_LOAD;
      end
      S_LOAD: begin
        cur_lines_n  = head_lines;
        lines_done_n = '0;
        tcnt_n       = '0;
        if (head_lines == '0 || head_lines > LW'(MAXL)) begin
          state_n = S_ERROR;
        end else begin
          state_n  = S_ISSUE;
          rdaddr_n = head_base;
        end
      end
      S_ISSUE: begin
        tcnt_n  = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the final tolerated cycle still counts as success
        if (div_done) begin
          lines_done_n = lines_done + LW'(1);
          tcnt_n       = '0;
          if (lines_done + LW'(1) == cur_lines) begin
            state_n = S_COMPLETE;
          end else begin
            state_n  = S_ISSUE;
            rdaddr_n = sc_mem_rdaddr + AW'(STRIDE);
          end
        end else if (tcnt >= TW'(TIMEOUT - 1)) begin
          state_n = S_ERROR;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      S_COMPLETE: state_n = S_IDLE;
      S_ERROR:    state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cur_lines     <= '0;
      lines_done    <= '0;
      sc_mem_rdaddr <= '0;
      tcnt          <= '0;
      sc_mem_rd_en  <= 1'b0;
      job_done      <= 1'b0;
      job_err       <= 1'b0;
      busy          <= 1'b0;
      job_ready     <= 1'b1;
    end else begin
      state         <= state_n;
      cur_lines     <= cur_lines_n;
      lines_done    <= lines_done_n;
      sc_mem_rdaddr <= rdaddr_n;
      tcnt          <= tcnt_n;
      sc_mem_rd_en  <= (state_n == S_ISSUE);
      job_done      <= (state_n == S_COMPLETE);
      job_err       <= (state_n == S_ERROR);
      busy          <= (state_n != S_IDLE) || (q_cnt_n != '0);
      job_ready     <= (q_cnt_n < CW'(QDEPTH));
    end
  end

endmodule

// File: tb/tb_divider_job_sched.sv
// Self-checking bench for divider_job_sched: vector table, directed corner
// sequences and randomized jobs checked against a transaction-level model.
module tb_divider_job_sched;
  localparam int STRIDE_TB = 2;

  logic        clk, reset, job_valid, job_ready, div_done;
  logic        sc_mem_rd_en, job_done, job_err, busy;
  logic [15:0] job_base, sc_mem_rdaddr;
  logic [6:0]  job_lines, lines_done;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_delay = 3;
  bit resp_rand = 0;
  int cyc = 0;
  int last_rd_cyc = 0;
  int err_cyc = 0;
  logic [15:0] addr_q[$];
  int kind_q[$];
  int ld_q[$];

  typedef struct {
    logic [15:0] base;
    logic [6:0]  lines;
    int          delay;
    int          exp_reads;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_kind;
    int          exp_ld;
  } vec_t;

  divider_job_sched #(.STRIDE(2), .TIMEOUT(255), .QDEPTH(2)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_base(job_base), .job_lines(job_lines), .div_done(div_done),
    .sc_mem_rdaddr(sc_mem_rdaddr), .sc_mem_rd_en(sc_mem_rd_en),
    .job_done(job_done), .job_err(job_err), .busy(busy), .lines_done(lines_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Divider core stand-in: answers each read after a chosen number of WAIT cycles
  initial begin
    div_done = 0;
    forever begin
      @(negedge clk);
      if (sc_mem_rd_en && reset && resp_delay != 0) begin
        int d;
        d = resp_rand ? int'($urandom_range(1, 6)) : resp_delay;
        repeat (d) @(posedge clk);
        #1 div_done = 1;
        @(posedge clk);
        #1 div_done = 0;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (sc_mem_rd_en) begin
      addr_q.push_back(sc_mem_rdaddr);
      last_rd_cyc = cyc;
    end
    if (job_done) begin
      kind_q.push_back(1);
      ld_q.push_back(int'(lines_done));
    end
    if (job_err) begin
      kind_q.push_back(2);
      ld_q.push_back(int'(lines_done));
      err_cyc = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    addr_q.delete();
    kind_q.delete();
    ld_q.delete();
  endtask

  task automatic push_job(input logic [15:0] b, input logic [6:0] l);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1 job_valid = 1; job_base = b; job_lines = l;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (job_ready) begin ok = 1; break; end
    end
    @(posedge clk);
    #1 job_valid = 0;
    if (!ok) chk("push_accept", 0, 1);
  endtask

  task automatic wait_idle(input string name, input int n, input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy && kind_q.size() >= n) begin ok = 1; break; end
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic chk_seq(input string name, input logic [15:0] exp[$]);
    chk({name, "_nreads"}, addr_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < addr_q.size(); i++)
      chk($sformatf("%s_addr%0d", name, i), int'(addr_q[i]), int'(exp[i]));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  int'(job_ready), 1);
    chk({tag, "_rd_en"},  int'(sc_mem_rd_en), 0);
    chk({tag, "_rdaddr"}, int'(sc_mem_rdaddr), 0);
    chk({tag, "_done"},   int'(job_done), 0);
    chk({tag, "_err"},    int'(job_err), 0);
    chk({tag, "_busy"},   int'(busy), 0);
    chk({tag, "_ld"},     int'(lines_done), 0);
  endtask

  initial begin
    vec_t v[9];
    logic [15:0] exp_addr[$];
    int exp_kind[$];
    int exp_ld[$];

    v[0] = '{16'd64,   7'd3,   5,   3,  16'd64,   16'd68,   1, 3};
    v[1] = '{16'hFFFE, 7'd2,   2,   2,  16'hFFFE, 16'h0000, 1, 2};
    v[2] = '{16'h1000, 7'd0,   3,   0,  16'h0,    16'h0,    2, 0};
    v[3] = '{16'h2000, 7'd65,  3,   0,  16'h0,    16'h0,    2, 0};
    v[4] = '{16'h2000, 7'd127, 3,   0,  16'h0,    16'h0,    2, 0};
    v[5] = '{16'h3000, 7'd64,  1,   64, 16'h3000, 16'h307E, 1, 64};
    v[6] = '{16'h0010, 7'd1,   255, 1,  16'h0010, 16'h0010, 1, 1};
    v[7] = '{16'h0020, 7'd2,   0,   1,  16'h0020, 16'h0020, 2, 0};
    v[8] = '{16'h0030, 7'd3,   7,   3,  16'h0030, 16'h0034, 1, 3};

    job_valid = 0; job_base = 0; job_lines = 0; reset = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk);
    #1 reset = 1;

    // Single job with first-read latency check
    clear_mon(); resp_delay = 5;
    @(posedge clk);
    #1 job_valid = 1; job_base = 16'd64; job_lines = 7'd3;
    @(negedge clk); chk("lat_ready", int'(job_ready), 1);
    @(posedge clk);
    #1 job_valid = 0;
    @(negedge clk); chk("lat_e0_rd_en", int'(sc_mem_rd_en), 0); chk("lat_e0_busy", int'(busy), 1);
    @(negedge clk); chk("lat_e1_rd_en", int'(sc_mem_rd_en), 0);
    @(negedge clk); chk("lat_e2_rd_en", int'(sc_mem_rd_en), 1); chk("lat_e2_addr", int'(sc_mem_rdaddr), 64);
    wait_idle("j1_end", 1, 300);
    exp_addr.delete(); exp_addr.push_back(16'd64); exp_addr.push_back(16'd66); exp_addr.push_back(16'd68);
    chk_seq("j1", exp_addr);
    chk("j1_jobs", kind_q.size(), 1);
    chk("j1_ld", int'(lines_done), 3);

    // Three back-to-back requests against a two-entry queue
    clear_mon(); resp_delay = 2;
    @(posedge clk);
    #1 job_valid = 1; job_base = 16'h0100; job_lines = 7'd1;
    @(negedge clk); chk("bb_ready_a", int'(job_ready), 1);
    @(posedge clk);
    #1 job_base = 16'h0200;
    @(negedge clk); chk("bb_ready_b", int'(job_ready), 1);
    @(posedge clk);
    #1 job_base = 16'h0300;
    @(negedge clk); chk("bb_ready_full", int'(job_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk); chk("bb_ready_after_pop", int'(job_ready), 1);
    @(posedge clk);
    #1 job_valid = 0;
    wait_idle("bb_end", 3, 500);
    exp_addr.delete(); exp_addr.push_back(16'h0100); exp_addr.push_back(16'h0200); exp_addr.push_back(16'h0300);
    chk_seq("bb", exp_addr);
    chk("bb_dones", kind_q.size(), 3);

    // Zero-length job followed by a normal queued job
    clear_mon(); resp_delay = 3;
    @(posedge clk);
    #1 job_valid = 1; job_base = 16'h0500; job_lines = 7'd0;
    @(negedge clk);
    @(posedge clk);
    #1 job_base = 16'h0040; job_lines = 7'd2;
    @(negedge clk);
    @(posedge clk);
    #1 job_valid = 0;
    @(negedge clk); chk("zl_err_in_load", int'(job_err), 0);
    @(negedge clk); chk("zl_err", int'(job_err), 1); chk("zl_rd_en", int'(sc_mem_rd_en), 0);
    @(negedge clk); chk("zl_err_width", int'(job_err), 0);
    wait_idle("zl_end", 2, 300);
    exp_addr.delete(); exp_addr.push_back(16'h0040); exp_addr.push_back(16'h0042);
    chk_seq("zl", exp_addr);
    chk("zl_kind0", kind_q.size() > 0 ? kind_q[0] : 0, 2);
    chk("zl_kind1", kind_q.size() > 1 ? kind_q[1] : 0, 1);

    // Vector table
    for (int k = 0; k < 9; k++) begin
      clear_mon(); resp_delay = v[k].delay;
      push_job(v[k].base, v[k].lines);
      wait_idle($sformatf("v%0d_end", k), 1, 2000);
      chk($sformatf("v%0d_reads", k), addr_q.size(), v[k].exp_reads);
      if (v[k].exp_reads > 0 && addr_q.size() > 0) begin
        chk($sformatf("v%0d_first", k), int'(addr_q[0]), int'(v[k].exp_first));
        chk($sformatf("v%0d_last", k), int'(addr_q[addr_q.size()-1]), int'(v[k].exp_last));
      end
      chk($sformatf("v%0d_kind", k), kind_q.size() > 0 ? kind_q[0] : 0, v[k].exp_kind);
      chk($sformatf("v%0d_ld_pulse", k), ld_q.size() > 0 ? ld_q[0] : -1, v[k].exp_ld);
      chk($sformatf("v%0d_ld_hold", k), int'(lines_done), v[k].exp_ld);
      if (v[k].delay == 0 && v[k].exp_reads == 1)
        chk($sformatf("v%0d_timeout_gap", k), err_cyc - last_rd_cyc, 256);
    end

    // Reset in WAIT with one job queued
    clear_mon(); resp_delay = 20;
    push_job(16'h0700, 7'd4);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sc_mem_rd_en) break;
    end
    push_job(16'h0800, 7'd2);
    @(posedge clk);
    #3 reset = 0;
    #1;
    chk_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1;
    repeat (40) @(negedge clk);
    chk("mid_rst_no_pulse", kind_q.size(), 0);
    chk("mid_rst_reads", addr_q.size(), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(job_ready), 1);

    // Randomized jobs against a transaction-level model
    clear_mon(); resp_rand = 1;
    exp_addr.delete(); exp_kind.delete(); exp_ld.delete();
    for (int j = 0; j < 24; j++) begin
      logic [15:0] b;
      logic [6:0]  l;
      int r;
      b = 16'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0)      l = 7'd0;
      else if (r == 1) l = 7'($urandom_range(65, 127));
      else             l = 7'($urandom_range(1, 6));
      push_job(b, l);
      if (l == 0 || l > 64) begin
        exp_kind.push_back(2); exp_ld.push_back(0);
      end else begin
        for (int i = 0; i < int'(l); i++)
          exp_addr.push_back(16'((int'(b) + i * STRIDE_TB) % 65536));
        exp_kind.push_back(1); exp_ld.push_back(int'(l));
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle("rnd_end", 24, 6000);
    chk_seq("rnd", exp_addr);
    chk("rnd_jobs", kind_q.size(), exp_kind.size());
    for (int i = 0; i < exp_kind.size() && i < kind_q.size(); i++) begin
      chk($sformatf("rnd_kind%0d", i), kind_q[i], exp_kind[i]);
      chk($sformatf("rnd_ld%0d", i), ld_q[i], exp_ld[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_job_sched.md
DIVIDER_JOB_SCHED -- requirements
Module: divider_job_sched

Interface
REQ-001 Parameter STRIDE, default 2: address increment between consecutive scratchpad line reads.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles tolerated without div_done.
REQ-003 Parameter QDEPTH, fixed 2: job queue depth.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 job_valid  in  1  job request valid.
REQ-007 job_ready  out  1  queue can accept a job.
REQ-008 job_base  in  16  scratchpad start address of the job.
REQ-009 job_lines  in  7  number of lines to divide; legal range 1..64.
REQ-010 div_done  in  1  divider core finished current line (1-cycle pulse).
REQ-011 sc_mem_rdaddr  out  16  scratchpad read address.
REQ-012 sc_mem_rd_en  out  1  scratchpad read strobe.
REQ-013 job_done  out  1  1-cycle pulse: job completed normally.
REQ-014 job_err  out  1  1-cycle pulse: job aborted (zero length or timeout).
REQ-015 busy  out  1  high while FSM not IDLE or queue non-empty.
REQ-016 lines_done  out  7  lines completed in current job.

Function
REQ-017 Queue SHALL be a 2-entry FIFO of {job_base, job_lines}; push on job_valid && job_ready; job_ready = (occupancy < 2), no combinational path from job_valid.
REQ-018 Push and pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-019 FSM states SHALL be IDLE, LOAD, ISSUE, WAIT, COMPLETE, ERROR.
REQ-020 IDLE: queue non-empty -> LOAD; else stay.
REQ-021 LOAD: pop head into job registers, clear line index, lines_done and timeout counter; job_lines == 0 -> ERROR, else -> ISSUE.
REQ-022 ISSUE: sc_mem_rd_en SHALL be high exactly the one cycle the FSM is in ISSUE; sc_mem_rdaddr = job_base + index*STRIDE, modulo 2^16 (wraps silently); -> WAIT.
REQ-023 WAIT: sc_mem_rd_en low; timeout counter increments each cycle; div_done -> index+1, lines_done+1, and -> COMPLETE if index+1 == job_lines else -> ISSUE.
REQ-024 WAIT: counter reaching TIMEOUT with div_done low SHALL go to ERROR; div_done on that same cycle wins (line counted, no error).
REQ-025 div_done outside WAIT SHALL be ignored.
REQ-026 COMPLETE: job_done high one cycle -> IDLE. ERROR: job_err high one cycle -> IDLE; lines_done holds its last value until next LOAD.
REQ-027 sc_mem_rdaddr SHALL hold its last value outside ISSUE.
REQ-028 Latency: job accepted at edge E0 with FSM IDLE and queue empty -> LOAD after E1, sc_mem_rd_en high after E2.
REQ-029 job_lines values > 64 SHALL be treated as error (-> ERROR from LOAD).

Reset
REQ-030 reset low SHALL immediately force: FSM IDLE, queue empty, job_ready 1, sc_mem_rdaddr 0, sc_mem_rd_en 0, job_done 0, job_err 0, busy 0, lines_done 0, counters 0.
REQ-031 reset asserted mid-job SHALL discard the active and all queued jobs with no job_done/job_err pulse; operation resumes on first edge after deassertion.

Verification
REQ-032 Single job base 64, lines 3, div_done 5 cycles after each read -> rd_en pulses at addresses 64, 66, 68; one job_done; lines_done 3.
REQ-033 Three back-to-back job_valid with no pops -> job_ready low after two accepts; third held until LOAD pops, then accepted; jobs execute in order.
REQ-034 job_lines 0 -> no rd_en, job_err one cycle after LOAD; next queued job then runs normally.
REQ-035 Withhold div_done -> job_err after 255 WAIT cycles; repeat with div_done on cycle 255 -> no error, line counted.
REQ-036 job_base 0xFFFE, lines 2, STRIDE 2 -> reads at 0xFFFE then 0x0000.
REQ-037 Assert reset in WAIT with one job queued -> all outputs at reset values asynchronously, queue empty, no done/err pulse.
